// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared types for the I2C request arbiter            rev 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      GAP    = 3'd3,
      FINISH = 3'd4
   } arb_state_t;

   typedef struct packed {
      logic [I2C_ADDR_W-1:0] addr;
      logic [I2C_DATA_W-1:0] wdata;
      logic                  write;
   } i2c_cmd_t;

endpackage : i2c_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin selector (first set bit at/after ptr)
// rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]     w_off;
   logic                 w_found;
   logic [NUM_REQ-1:0]   w_oh_rot;
   logic [2*NUM_REQ-1:0] w_oh_dbl;
   logic [IDX_W:0]       w_sum;

   // Rotate so bit k of w_rot is requester (ptr + k) mod NUM_REQ.
   assign w_req_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot     = w_req_dbl[NUM_REQ-1:0];

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = IDX_W'(k);
         end
      end
   end

   assign w_oh_rot = w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_off) : '0;
   assign w_oh_dbl = {w_oh_rot, w_oh_rot} << i_ptr;
   assign o_onehot = w_oh_dbl[2*NUM_REQ-1:NUM_REQ];

   assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
   assign o_idx   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                   : IDX_W'(w_sum);
   assign o_valid = w_found;

endmodule : rr_pick

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// i2c_req_arbiter : round-robin share of one I2C master core, with retry
// and watchdog                                                   rev 1.0
// ============================================================================
`default_nettype none

module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int MAX_RETRY      = 2,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*I2C_ADDR_W-1:0] i_req_addr,
   input  logic [NUM_REQ*I2C_DATA_W-1:0] i_req_wdata,
   input  logic [NUM_REQ-1:0]            i_req_write,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [NUM_REQ-1:0]            o_done,
   output logic [NUM_REQ-1:0]            o_err,
   output logic [I2C_DATA_W-1:0]         o_rdata,
   output logic [I2C_ADDR_W-1:0]         o_m_addr,
   output logic [I2C_DATA_W-1:0]         o_m_wdata,
   output logic                          o_m_write,
   output logic                          o_m_dv,
   input  logic                          i_m_ready,
   input  logic                          i_m_data_valid,
   input  logic [I2C_DATA_W-1:0]         i_m_rdata,
   input  logic                          i_m_error
);

   localparam int c_idx_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_retry_w = $clog2(MAX_RETRY + 1);
   localparam int c_gap_w   = $clog2(GAP_CYCLES + 1);
   localparam int c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);
   localparam logic [c_gap_w-1:0]   c_gap_max   = c_gap_w'(GAP_CYCLES);
   localparam logic [c_tmo_w-1:0]   c_tmo_max   = c_tmo_w'(TIMEOUT_CYCLES);
   localparam logic [c_idx_w-1:0]   c_last_idx  = c_idx_w'(NUM_REQ - 1);

   arb_state_t                r_state;
   i2c_cmd_t                  r_cmd;
   logic [NUM_REQ-1:0]        r_gnt;
   logic [NUM_REQ-1:0]        r_done;
   logic [NUM_REQ-1:0]        r_err;
   logic [c_idx_w-1:0]        r_idx;
   logic [c_idx_w-1:0]        r_ptr;
   logic [c_retry_w-1:0]      r_retry;
   logic [c_gap_w-1:0]        r_gap;
   logic [c_tmo_w-1:0]        r_tmo;
   logic [I2C_DATA_W-1:0]     r_rdata;

   i2c_cmd_t [NUM_REQ-1:0]    w_cmds;
   logic [NUM_REQ-1:0]        w_pick_oh;
   logic [c_idx_w-1:0]        w_pick_idx;
   logic                      w_pick_vld;
   logic [c_gap_w-1:0]        w_gap_nxt;
   logic [c_tmo_w-1:0]        w_tmo_nxt;
   logic [c_idx_w-1:0]        w_ptr_nxt;

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign w_cmds[g].addr  = i_req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
         assign w_cmds[g].wdata = i_req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
         assign w_cmds[g].write = i_req_write[g];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_vld)
   );

   // Counters saturate at their terminal value instead of wrapping.
   assign w_gap_nxt = (r_gap == c_gap_max) ? r_gap : r_gap + 1'b1;
   assign w_tmo_nxt = (r_tmo == c_tmo_max) ? r_tmo : r_tmo + 1'b1;
   assign w_ptr_nxt = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cmd   <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_err   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_retry <= '0;
         r_gap   <= '0;
         r_tmo   <= '0;
         r_rdata <= '0;
      end else begin
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            IDLE: begin
               if (w_pick_vld) begin
                  r_cmd   <= w_cmds[w_pick_idx];
                  r_gnt   <= w_pick_oh;
                  r_idx   <= w_pick_idx;
                  r_retry <= '0;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_m_ready) begin
                  r_tmo   <= '0;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // Error has priority over a simultaneous completion.
               if (i_m_error) begin
                  if (r_retry < c_max_retry) begin
                     r_retry <= r_retry + 1'b1;
                     r_gap   <= '0;
                     r_state <= GAP;
                  end else begin
                     r_err   <= r_gnt;
                     r_state <= FINISH;
                  end
               end else if (r_cmd.write && i_m_ready) begin
                  r_done  <= r_gnt;
                  r_state <= FINISH;
               end else if (!r_cmd.write && i_m_data_valid) begin
                  r_rdata <= i_m_rdata;
                  r_done  <= r_gnt;
                  r_state <= FINISH;
               end else if (w_tmo_nxt == c_tmo_max) begin
                  r_err   <= r_gnt;
                  r_state <= FINISH;
               end else begin
                  r_tmo <= w_tmo_nxt;
               end
            end
            GAP: begin
               if (w_gap_nxt == c_gap_max) begin
                  r_state <= ISSUE;
               end else begin
                  r_gap <= w_gap_nxt;
               end
            end
            FINISH: begin
               r_gnt   <= '0;
               r_ptr   <= w_ptr_nxt;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // dv is qualified by ready combinationally so it can never fire while the core is busy.
   assign o_m_dv    = (r_state == ISSUE) && i_m_ready;
   assign o_m_addr  = r_cmd.addr;
   assign o_m_wdata = r_cmd.wdata;
   assign o_m_write = r_cmd.write;
   assign o_gnt     = r_gnt;
   assign o_done    = r_done;
   assign o_err     = r_err;
   assign o_rdata   = r_rdata;

endmodule : i2c_req_arbiter

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// tb_i2c_req_arbiter : scoreboard bench with a small I2C core model
// rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_req_arbiter;

   localparam int N    = 2;
   localparam int MAXR = 2;
   localparam int GAPC = 4;
   localparam int TMO  = 20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*7-1:0]   req_addr = '0;
   logic [N*8-1:0]   req_wdata = '0;
   logic [N-1:0]     req_write = '0;
   logic [N-1:0]     gnt, done, err;
   logic [7:0]       rdata;
   logic [6:0]       m_addr;
   logic [7:0]       m_wdata;
   logic             m_write, m_dv;
   logic             m_ready = 1'b1;
   logic             m_data_valid = 1'b0;
   logic [7:0]       m_rdata = '0;
   logic             m_error = 1'b0;

   i2c_req_arbiter #(
      .NUM_REQ(N), .MAX_RETRY(MAXR), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(req), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_write(req_write),
      .o_gnt(gnt), .o_done(done), .o_err(err), .o_rdata(rdata),
      .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_write(m_write), .o_m_dv(m_dv),
      .i_m_ready(m_ready), .i_m_data_valid(m_data_valid), .i_m_rdata(m_rdata),
      .i_m_error(m_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       write;
   } dv_t;

   typedef struct packed {
      logic       is_err;
      logic [2:0] idx;
      logic       chk_rd;
      logic [7:0] rdata;
      logic       tmo;
   } rsp_t;

   dv_t        exp_dv[$];
   rsp_t       exp_rsp[$];
   logic [1:0] plan_q[$];      // 0 ok, 1 core error, 2 hang
   logic [7:0] plan_rd[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_dv     = 0;
   int last_dv_cyc  = 0;
   int last_err_cyc = 0;
   bit gap_pending  = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic push_x(input logic [6:0] a, input logic [7:0] d, input logic w,
                         input logic [1:0] plan, input logic [7:0] prd);
      dv_t e;
      e.addr = a; e.wdata = d; e.write = w;
      exp_dv.push_back(e);
      plan_q.push_back(plan);
      plan_rd.push_back(prd);
   endtask

   task automatic push_r(input logic is_err, input int idx, input logic chk_rd,
                         input logic [7:0] rd, input logic tmo);
      rsp_t r;
      r.is_err = is_err; r.idx = 3'(idx); r.chk_rd = chk_rd; r.rdata = rd; r.tmo = tmo;
      exp_rsp.push_back(r);
   endtask

   task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic w);
      req_addr[i*7 +: 7]  = a;
      req_wdata[i*8 +: 8] = d;
      req_write[i]        = w;
      req[i]              = 1'b1;
   endtask

   // Requester side: wait for its done/err pulse, then drop req.
   task automatic wait_rsp(input int i, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (done[i] || err[i]) seen = 1'b1;
      end
      req[i] = 1'b0;
      if (!seen) chk("wait_rsp_timeout", 0, 1);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_error) begin
            last_err_cyc = cyc;
            gap_pending  = 1'b1;
         end
         if (m_dv) begin
            n_dv++;
            chk("dv_while_ready", 32'(m_ready), 1);
            if (gap_pending) begin
               chk("retry_gap", 32'(cyc - last_err_cyc > GAPC), 1);
               gap_pending = 1'b0;
            end
            if (exp_dv.size() == 0) begin
               chk("dv_unexpected", 1, 0);
            end else begin
               dv_t e;
               e = exp_dv.pop_front();
               chk("dv_cmd", 32'({m_addr, m_wdata, m_write}), 32'(e));
            end
            last_dv_cyc = cyc;
         end
         if (done != '0 || err != '0) begin
            if (err != '0) gap_pending = 1'b0;
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", 32'({done, err}), 0);
            end else begin
               rsp_t r;
               r = exp_rsp.pop_front();
               chk("rsp_done", 32'(done), r.is_err ? 0 : (32'd1 << r.idx));
               chk("rsp_err",  32'(err),  r.is_err ? (32'd1 << r.idx) : 0);
               if (r.chk_rd) chk("rsp_rdata", 32'(rdata), 32'(r.rdata));
               if (r.tmo)    chk("tmo_latency", 32'(cyc - last_dv_cyc), TMO + 1);
            end
         end
      end
   end

   // I2C core model: busy after dv, then respond per the plan queue.
   initial begin
      logic [1:0] pl;
      logic [7:0] prd;
      forever begin
         @(negedge clk);
         if (rst_n && m_dv) begin
            pl = 2'd0; prd = 8'h00;
            if (plan_q.size() > 0) begin
               pl  = plan_q.pop_front();
               prd = plan_rd.pop_front();
            end
            @(posedge clk); #1 m_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            case (pl)
               2'd0: begin
                  if (m_write) begin
                     m_ready = 1'b1;
                  end else begin
                     m_rdata = prd; m_data_valid = 1'b1; m_ready = 1'b1;
                     @(posedge clk); #1 m_data_valid = 1'b0;
                  end
               end
               2'd1: begin
                  m_error = 1'b1; m_ready = 1'b1;
                  @(posedge clk); #1 m_error = 1'b0;
               end
               default: begin
                  for (int k = 0; k < 400 && rst_n && err == '0; k++) @(negedge clk);
                  m_ready = 1'b1;
               end
            endcase
         end
      end
   end

   initial begin
      int cnt;
      int base;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_pulses", 32'({done, err}), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_core_if", 32'({m_addr, m_wdata, m_write, m_dv}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single write
      push_x(7'h50, 8'hA5, 1'b1, 2'd0, 8'h00);
      push_r(1'b0, 0, 1'b0, 8'h00, 1'b0);
      set_req(0, 7'h50, 8'hA5, 1'b1);
      @(posedge clk); #1;
      chk("gnt_latency", 32'(gnt), 32'b01);
      wait_rsp(0, 100);

      // 2: read
      push_x(7'h3C, 8'h00, 1'b0, 2'd0, 8'h5A);
      push_r(1'b0, 1, 1'b1, 8'h5A, 1'b0);
      set_req(1, 7'h3C, 8'h00, 1'b0);
      wait_rsp(1, 100);
      repeat (5) @(negedge clk);
      chk("rdata_hold", 32'(rdata), 32'h5A);

      // 3: contention, pointer at 0 -> 0,1,0,1
      for (int t = 0; t < 4; t++) begin
         if (t % 2 == 0) push_x(7'h11, 8'h01, 1'b1, 2'd0, 8'h00);
         else            push_x(7'h22, 8'h02, 1'b1, 2'd0, 8'h00);
         push_r(1'b0, t % 2, 1'b0, 8'h00, 1'b0);
      end
      set_req(0, 7'h11, 8'h01, 1'b1);
      set_req(1, 7'h22, 8'h02, 1'b1);
      cnt = 0;
      for (int k = 0; k < 400 && cnt < 4; k++) begin
         @(negedge clk);
         if (done != '0) cnt++;
      end
      req = '0;
      chk("contention_cnt", 32'(cnt), 4);

      // 4a: two errors then success
      for (int t = 0; t < 3; t++) push_x(7'h44, 8'h10, 1'b1, (t < 2) ? 2'd1 : 2'd0, 8'h00);
      push_r(1'b0, 0, 1'b0, 8'h00, 1'b0);
      set_req(0, 7'h44, 8'h10, 1'b1);
      wait_rsp(0, 300);

      // 4b: errors on all attempts
      base = n_dv;
      for (int t = 0; t < 3; t++) push_x(7'h45, 8'h20, 1'b1, 2'd1, 8'h00);
      push_r(1'b1, 0, 1'b0, 8'h00, 1'b0);
      set_req(0, 7'h45, 8'h20, 1'b1);
      wait_rsp(0, 300);
      repeat (2 * GAPC + 20) @(negedge clk);
      chk("no_extra_dv", 32'(n_dv - base), 3);

      // 5: timeout, then the other requester is served
      push_x(7'h55, 8'h30, 1'b1, 2'd2, 8'h00);
      push_r(1'b1, 0, 1'b0, 8'h00, 1'b1);
      push_x(7'h66, 8'h40, 1'b1, 2'd0, 8'h00);
      push_r(1'b0, 1, 1'b0, 8'h00, 1'b0);
      set_req(0, 7'h55, 8'h30, 1'b1);
      repeat (2) @(negedge clk);
      set_req(1, 7'h66, 8'h40, 1'b1);
      wait_rsp(0, TMO + 50);
      @(negedge clk);
      chk("tmo_gnt_drop", 32'(gnt), 0);
      wait_rsp(1, 100);

      // 6: reset during WAIT
      push_x(7'h12, 8'h34, 1'b1, 2'd0, 8'h00);
      push_r(1'b0, 0, 1'b0, 8'h00, 1'b0);
      set_req(0, 7'h12, 8'h34, 1'b1);
      wait_rsp(0, 100);
      push_x(7'h13, 8'h35, 1'b1, 2'd2, 8'h00);
      set_req(0, 7'h13, 8'h35, 1'b1);
      repeat (6) @(negedge clk);
      chk("pre_rst_gnt", 32'(gnt), 32'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_outs", 32'({done, err, m_dv, m_addr, m_wdata, m_write}), 0);
      chk("arst_rdata", 32'(rdata), 0);
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_x(7'h14, 8'h36, 1'b1, 2'd0, 8'h00);
      push_r(1'b0, 1, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      set_req(1, 7'h14, 8'h36, 1'b1);
      @(posedge clk); #1;
      chk("post_rst_gnt", 32'(gnt), 32'b10);
      wait_rsp(1, 100);

      repeat (5) @(negedge clk);
      chk("sb_rsp_empty", 32'(exp_rsp.size()), 0);
      chk("sb_dv_empty", 32'(exp_dv.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule : tb_i2c_req_arbiter

`default_nettype wire
